// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between CPU issue logic (master) and alu_seq (slave).
interface alu_seq_if;
    logic        alu_seq__req_valid;
    logic        alu_seq__req_ready;
    logic [4:0]  alu_seq__req_op;
    logic        alu_seq__req_mul;
    logic [31:0] alu_seq__req_left;
    logic [31:0] alu_seq__req_right;
    logic        alu_seq__rsp_valid;
    logic        alu_seq__rsp_ready;
    logic [31:0] alu_seq__rsp_data;
    logic        alu_seq__rsp_cond;

    modport master (
        output alu_seq__req_valid, alu_seq__req_op, alu_seq__req_mul,
               alu_seq__req_left, alu_seq__req_right, alu_seq__rsp_ready,
        input  alu_seq__req_ready, alu_seq__rsp_valid, alu_seq__rsp_data,
               alu_seq__rsp_cond
    );

    modport slave (
        input  alu_seq__req_valid, alu_seq__req_op, alu_seq__req_mul,
               alu_seq__req_left, alu_seq__req_right, alu_seq__rsp_ready,
        output alu_seq__req_ready, alu_seq__rsp_valid, alu_seq__rsp_data,
               alu_seq__rsp_cond
    );
endinterface

// File: rtl/alu_seq.sv
// ALU sequencer: registers one request, drives the combinational ALU, holds the result until taken.
// Define ALU_SEQ_MUL_EN to add the shift-add multiply path built from ALU_ADD steps.
module alu_seq #(
    parameter int MUL_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst_b,
    alu_seq_if.slave    bus,
    output logic [31:0] alu_seq__alu_left,
    output logic [31:0] alu_seq__alu_right,
    output logic [4:0]  alu_seq__alu_op,
    input  logic [31:0] alu_seq__alu_out,
    input  logic        alu_seq__alu_cond
);
    localparam logic [4:0] ALU_LEFT = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
    localparam int STEP_W = $clog2(MUL_STEPS + 1);
`else
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

    state_t      state_reg, state_next;
    logic [4:0]  op_reg;
    // In MUL, left_reg is the shifting multiplicand and right_reg the shifting multiplier.
    logic [31:0] left_reg;
    logic [31:0] right_reg;
    logic [31:0] rsp_data_reg;
    logic        rsp_cond_reg;

`ifdef ALU_SEQ_MUL_EN
    logic [31:0]       acc_reg;
    logic [STEP_W-1:0] step_reg;
    logic              mul_done;
    assign mul_done = (right_reg == 32'd0) || (step_reg == STEP_W'(MUL_STEPS));
`else
    logic unused_ok;
    assign unused_ok = ^{bus.alu_seq__req_mul, (MUL_STEPS > 0)};
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        alu_seq__alu_left  = 32'd0;
        alu_seq__alu_right = 32'd0;
        alu_seq__alu_op    = ALU_LEFT;
        case (state_reg)
            IDLE: begin
                if (bus.alu_seq__req_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    state_next = bus.alu_seq__req_mul ? MUL : EXEC;
`else
                    state_next = EXEC;
`endif
                end
            end
            EXEC: begin
                alu_seq__alu_left  = left_reg;
                alu_seq__alu_right = right_reg;
                alu_seq__alu_op    = op_reg;
                state_next         = RESP;
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                if (mul_done) begin
                    state_next = RESP;
                end else begin
                    alu_seq__alu_op    = ALU_ADD;
                    alu_seq__alu_left  = acc_reg;
                    alu_seq__alu_right = right_reg[0] ? left_reg : 32'd0;
                end
            end
`endif
            RESP: begin
                if (bus.alu_seq__rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op_reg       <= ALU_LEFT;
            left_reg     <= 32'd0;
            right_reg    <= 32'd0;
            rsp_data_reg <= 32'd0;
            rsp_cond_reg <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_reg      <= 32'd0;
            step_reg     <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.alu_seq__req_valid) begin
                        op_reg    <= bus.alu_seq__req_op;
                        left_reg  <= bus.alu_seq__req_left;
                        right_reg <= bus.alu_seq__req_right;
`ifdef ALU_SEQ_MUL_EN
                        acc_reg   <= 32'd0;
                        step_reg  <= '0;
`endif
                    end
                end
                EXEC: begin
                    rsp_data_reg <= alu_seq__alu_out;
                    rsp_cond_reg <= alu_seq__alu_cond;
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    if (mul_done) begin
                        rsp_data_reg <= acc_reg;
                        rsp_cond_reg <= acc_reg[0];
                    end else begin
                        acc_reg   <= alu_seq__alu_out;
                        left_reg  <= left_reg << 1;
                        right_reg <= right_reg >> 1;
                        step_reg  <= step_reg + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.alu_seq__req_ready = (state_reg == IDLE);
    assign bus.alu_seq__rsp_valid = (state_reg == RESP);
    assign bus.alu_seq__rsp_data  = rsp_data_reg;
    assign bus.alu_seq__rsp_cond  = rsp_cond_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU; multiply checks run only when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
    localparam logic [4:0] ALU_LEFT = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_LT   = 5'd3;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] alu_left, alu_right, alu_out;
    logic [4:0]  alu_op;
    logic        alu_cond;
    int          tests_run = 0;
    int          tests_failed = 0;

    alu_seq_if bus ();

    alu_seq #(.MUL_STEPS(32)) dut (
        .clk                (clk),
        .rst_b              (rst_b),
        .bus                (bus.slave),
        .alu_seq__alu_left  (alu_left),
        .alu_seq__alu_right (alu_right),
        .alu_seq__alu_op    (alu_op),
        .alu_seq__alu_out   (alu_out),
        .alu_seq__alu_cond  (alu_cond)
    );

    always #5 clk = ~clk;

    // Reference ALU; condition is bit 0 of the result.
    always_comb begin
        case (alu_op)
            ALU_LEFT: alu_out = alu_left;
            ALU_ADD:  alu_out = alu_left + alu_right;
            ALU_SUB:  alu_out = alu_left - alu_right;
            ALU_LT:   alu_out = {31'd0, alu_left < alu_right};
            default:  alu_out = 32'd0;
        endcase
        alu_cond = alu_out[0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [4:0] op, input logic mul,
                             input logic [31:0] l, input logic [31:0] r);
        bus.alu_seq__req_valid = 1'b1;
        bus.alu_seq__req_op    = op;
        bus.alu_seq__req_mul   = mul;
        bus.alu_seq__req_left  = l;
        bus.alu_seq__req_right = r;
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus.alu_seq__req_ready !== 1'b1 || bus.alu_seq__rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1 0", bus.alu_seq__req_ready, bus.alu_seq__rsp_valid);
        end
        tests_run++;
        if (bus.alu_seq__rsp_data !== 32'd0 || bus.alu_seq__rsp_cond !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rsp: data=%h cond=%b want 0 0", bus.alu_seq__rsp_data, bus.alu_seq__rsp_cond);
        end
        tests_run++;
        if (alu_left !== 32'd0 || alu_right !== 32'd0 || alu_op !== ALU_LEFT) begin
            tests_failed++;
            $display("FAIL reset_alu: l=%h r=%h op=%0d want 0 0 %0d", alu_left, alu_right, alu_op, ALU_LEFT);
        end
        $display("[TB] reset state checked");
    endtask

    task automatic test_single_op();
        bus.alu_seq__rsp_ready = 1'b1;  // high before RESP must not matter
        drive_req(ALU_SUB, 1'b0, 32'd5, 32'd7);
        tick();
        bus.alu_seq__req_valid = 1'b0;
        tests_run++;
        if (alu_op !== ALU_SUB || alu_left !== 32'd5 || alu_right !== 32'd7 || bus.alu_seq__req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_exec: op=%0d l=%h r=%h ready=%b want %0d 5 7 0", alu_op, alu_left, alu_right, bus.alu_seq__req_ready, ALU_SUB);
        end
        tick();
        tests_run++;
        if (bus.alu_seq__rsp_valid !== 1'b1 || bus.alu_seq__rsp_data !== 32'hFFFFFFFE || bus.alu_seq__rsp_cond !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_rsp: valid=%b data=%h cond=%b want 1 fffffffe 0", bus.alu_seq__rsp_valid, bus.alu_seq__rsp_data, bus.alu_seq__rsp_cond);
        end
        tests_run++;
        if (alu_op !== ALU_LEFT || alu_left !== 32'd0) begin
            tests_failed++;
            $display("FAIL sub_alu_idle: op=%0d l=%h want %0d 0", alu_op, alu_left, ALU_LEFT);
        end
        tick();
        tests_run++;
        if (bus.alu_seq__req_ready !== 1'b1 || bus.alu_seq__rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_done: ready=%b valid=%b want 1 0", bus.alu_seq__req_ready, bus.alu_seq__rsp_valid);
        end
        $display("[TB] txn SUB 5,7 -> %h", bus.alu_seq__rsp_data);
    endtask

    task automatic test_backpressure();
        int bad;
        bus.alu_seq__rsp_ready = 1'b0;
        drive_req(ALU_LT, 1'b0, 32'd3, 32'd9);
        tick();
        bus.alu_seq__req_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.alu_seq__rsp_valid !== 1'b1 || bus.alu_seq__rsp_data !== 32'd1 ||
                bus.alu_seq__rsp_cond !== 1'b1 || bus.alu_seq__req_ready !== 1'b0)
                bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL lt_hold: %0d bad cycles (last valid=%b data=%h cond=%b ready=%b) want 0", bad,
                     bus.alu_seq__rsp_valid, bus.alu_seq__rsp_data, bus.alu_seq__rsp_cond, bus.alu_seq__req_ready);
        end
        bus.alu_seq__rsp_ready = 1'b1;
        tick();
        tests_run++;
        if (bus.alu_seq__req_ready !== 1'b1 || bus.alu_seq__rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lt_release: ready=%b valid=%b want 1 0", bus.alu_seq__req_ready, bus.alu_seq__rsp_valid);
        end
        $display("[TB] txn LT 3,9 -> %h (4 stall cycles)", bus.alu_seq__rsp_data);
    endtask

    task automatic test_back_to_back();
        bus.alu_seq__rsp_ready = 1'b1;
        drive_req(ALU_ADD, 1'b0, 32'd2, 32'd3);
        tick();
        drive_req(ALU_LEFT, 1'b0, 32'h0000ABCD, 32'd0);
        tick();
        tests_run++;
        if (bus.alu_seq__rsp_valid !== 1'b1 || bus.alu_seq__rsp_data !== 32'd5 || bus.alu_seq__rsp_cond !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first: valid=%b data=%h cond=%b want 1 5 1", bus.alu_seq__rsp_valid, bus.alu_seq__rsp_data, bus.alu_seq__rsp_cond);
        end
        tick();
        tests_run++;
        if (bus.alu_seq__req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready: ready=%b want 1", bus.alu_seq__req_ready);
        end
        tick();
        bus.alu_seq__req_valid = 1'b0;
        tests_run++;
        if (alu_op !== ALU_LEFT || alu_left !== 32'h0000ABCD) begin
            tests_failed++;
            $display("FAIL b2b_exec: op=%0d l=%h want %0d 0000abcd", alu_op, alu_left, ALU_LEFT);
        end
        tick();
        tests_run++;
        if (bus.alu_seq__rsp_valid !== 1'b1 || bus.alu_seq__rsp_data !== 32'h0000ABCD || bus.alu_seq__rsp_cond !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: valid=%b data=%h cond=%b want 1 0000abcd 1", bus.alu_seq__rsp_valid, bus.alu_seq__rsp_data, bus.alu_seq__rsp_cond);
        end
        tick();
        $display("[TB] txn ADD 2,3 then LEFT abcd back to back");
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output int cyc, output int adds);
        bus.alu_seq__rsp_ready = 1'b0;
        drive_req(ALU_SUB, 1'b1, a, b);
        tick();
        bus.alu_seq__req_valid = 1'b0;
        cyc = 1;
        adds = 0;
        while (bus.alu_seq__rsp_valid !== 1'b1 && cyc < 100) begin
            if (alu_op === ALU_ADD) adds++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_multiply();
        int cyc, adds;
        run_mul(32'd7, 32'd6, cyc, adds);
        tests_run++;
        if (cyc != 5 || adds != 3 || bus.alu_seq__rsp_data !== 32'd42 || bus.alu_seq__rsp_cond !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul_7x6: cyc=%0d adds=%0d data=%h cond=%b want 5 3 0000002a 0", cyc, adds, bus.alu_seq__rsp_data, bus.alu_seq__rsp_cond);
        end
        $display("[TB] txn MUL 7*6 -> %h", bus.alu_seq__rsp_data);
        bus.alu_seq__rsp_ready = 1'b1;
        tick();
        run_mul(32'h12345678, 32'd0, cyc, adds);
        tests_run++;
        if (cyc != 2 || adds != 0 || bus.alu_seq__rsp_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL mul_zero: cyc=%0d adds=%0d data=%h want 2 0 0", cyc, adds, bus.alu_seq__rsp_data);
        end
        $display("[TB] txn MUL 12345678*0 -> %h", bus.alu_seq__rsp_data);
        bus.alu_seq__rsp_ready = 1'b1;
        tick();
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, cyc, adds);
        tests_run++;
        if (cyc != 34 || adds != 32 || bus.alu_seq__rsp_data !== 32'd1 || bus.alu_seq__rsp_cond !== 1'b1) begin
            tests_failed++;
            $display("FAIL mul_ovf: cyc=%0d adds=%0d data=%h cond=%b want 34 32 1 1", cyc, adds, bus.alu_seq__rsp_data, bus.alu_seq__rsp_cond);
        end
        $display("[TB] txn MUL ffffffff*ffffffff -> %h", bus.alu_seq__rsp_data);
        bus.alu_seq__rsp_ready = 1'b1;
        tick();
    endtask
`else
    task automatic test_mul_disabled();
        bus.alu_seq__rsp_ready = 1'b1;
        drive_req(ALU_ADD, 1'b1, 32'd2, 32'd3);
        tick();
        bus.alu_seq__req_valid = 1'b0;
        tick();
        tests_run++;
        if (bus.alu_seq__rsp_valid !== 1'b1 || bus.alu_seq__rsp_data !== 32'd5) begin
            tests_failed++;
            $display("FAIL mul_off: valid=%b data=%h want 1 5", bus.alu_seq__rsp_valid, bus.alu_seq__rsp_data);
        end
        tick();
        $display("[TB] txn req_mul=1 ADD 2,3 -> %h", bus.alu_seq__rsp_data);
    endtask
`endif

    task automatic test_reset_mid_exec();
        int seen;
        bus.alu_seq__rsp_ready = 1'b0;
        drive_req(ALU_SUB, 1'b0, 32'd5, 32'd7);
        tick();
        bus.alu_seq__req_valid = 1'b0;
        #2;
        rst_b = 1'b0;
        #1;
        tests_run++;
        if (bus.alu_seq__rsp_valid !== 1'b0 || bus.alu_seq__req_ready !== 1'b1 || alu_op !== ALU_LEFT) begin
            tests_failed++;
            $display("FAIL rst_async: valid=%b ready=%b op=%0d want 0 1 %0d", bus.alu_seq__rsp_valid, bus.alu_seq__req_ready, alu_op, ALU_LEFT);
        end
        tests_run++;
        if (bus.alu_seq__rsp_data !== 32'd0 || alu_left !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_data: data=%h l=%h want 0 0", bus.alu_seq__rsp_data, alu_left);
        end
        tick();
        rst_b = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.alu_seq__rsp_valid !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL rst_no_rsp: rsp_valid high %0d cycles want 0", seen);
        end
        $display("[TB] reset mid-EXEC checked");
    endtask

    initial begin
        bus.alu_seq__req_valid = 1'b0;
        bus.alu_seq__req_op    = ALU_LEFT;
        bus.alu_seq__req_mul   = 1'b0;
        bus.alu_seq__req_left  = 32'd0;
        bus.alu_seq__req_right = 32'd0;
        bus.alu_seq__rsp_ready = 1'b0;
        tick();
        tick();
        rst_b = 1'b1;
        tick();
        test_reset();
        test_single_op();
        test_backpressure();
        test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
        test_multiply();
`else
        test_mul_disabled();
`endif
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencer that owns the driving side of the ALU port (`alu__left`, `alu__right`, `alu__op` out; `alu__out`, `alu__cond` in). It accepts operation requests on a valid/ready handshake, presents registered operands and op code to the combinational ALU, and captures the result into a response register with its own valid/ready handshake. Compound multiply is built from repeated `ALU_ADD` steps. It sits between the CPU issue logic and the `alu` instance.

## Interface
- `MUL_STEPS`, 32: maximum shift-add iterations per multiply (1..32).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `alu_seq__req_valid`  in  1  request present.
- `alu_seq__req_ready`  out  1  sequencer can accept; high only in IDLE.
- `alu_seq__req_op`  in  5  ALU op code, one of the `ALU_*` macros in `alu.vh`.
- `alu_seq__req_mul`  in  1  request is a multiply; `req_op` is ignored.
- `alu_seq__req_left`  in  32  left operand / multiplicand.
- `alu_seq__req_right`  in  32  right operand / multiplier.
- `alu_seq__rsp_valid`  out  1  response present.
- `alu_seq__rsp_ready`  in  1  consumer takes response.
- `alu_seq__rsp_data`  out  32  result.
- `alu_seq__rsp_cond`  out  1  condition bit of result.
- `alu_seq__alu_left`  out  32  to `alu__left`.
- `alu_seq__alu_right`  out  32  to `alu__right`.
- `alu_seq__alu_op`  out  5  to `alu__op`.
- `alu_seq__alu_out`  in  32  from `alu__out`.
- `alu_seq__alu_cond`  in  1  from `alu__cond`.

## Operation
- States: IDLE, EXEC, MUL, RESP. Reset state IDLE.
- Reset values: `req_ready`=1 (IDLE), `rsp_valid`=0, `rsp_data`=0, `rsp_cond`=0, ALU operands 0, `alu_op`=`ALU_LEFT`.
- IDLE: on `req_valid`&&`req_ready`, latch op, left, right. `req_mul`=1 -> MUL (acc=0, mcand=left, mplier=right, step=0); else -> EXEC.
- EXEC: drive latched left/right/op to ALU. At end of cycle capture `alu__out`->`rsp_data`, `alu__cond`->`rsp_cond`; -> RESP.
- MUL, each cycle: if mplier==0 or step==`MUL_STEPS`: `rsp_data`=acc, `rsp_cond`=acc[0], -> RESP, ALU unused. Else: drive `ALU_ADD`, left=acc, right = mplier[0] ? mcand : 0; acc<=`alu__out`; mcand<=mcand<<1; mplier<=mplier>>1; step++.
- Product is low 32 bits, unsigned modulo 2^32; overflow silently discarded.
- RESP: hold `rsp_valid`=1 with stable data/cond until `rsp_ready`; on handshake -> IDLE.
- Outside EXEC/MUL-add cycles, ALU outputs drive 0, 0, `ALU_LEFT`.
- Request fields are don't-care when not accepted. Op codes absent from `alu.vh` are illegal; response data is then undefined.
- Reset asserted mid-operation: immediate return to reset values; in-flight request and pending response lost, no response emitted.

## Timing
- Accept edge = edge 0. Single op: EXEC in cycle 1, `rsp_valid` high from cycle 2.
- Multiply with multiplier bit length n (n=0 for zero): n add cycles plus one terminate cycle; `rsp_valid` high from cycle n+2. With n > `MUL_STEPS`, `MUL_STEPS` add cycles; `rsp_valid` high from cycle `MUL_STEPS`+2; result truncated.
- `rsp_ready` high in first RESP cycle: `req_ready` high the following cycle. No request overlap; max throughput one single op per 3 cycles.
- `rsp_ready` high before RESP has no effect.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL state and multiply datapath present as above.
- Not defined: MUL state absent, `req_mul` ignored, every request executes as a single op via EXEC using `req_op`.

## Test plan
- Reset: drop `rst_b` mid-EXEC -> `rsp_valid`=0, `req_ready`=1, `alu_op`=`ALU_LEFT` immediately; no response after release.
- Single op: `ALU_SUB`, left=5, right=7 -> `rsp_valid` in cycle 2, data 0xFFFFFFFE, cond 0.
- Backpressure: `ALU_LT`, 3 vs 9, `rsp_ready` low 4 cycles -> data 1, cond 1 held stable, `req_ready` low throughout, high the cycle after handshake.
- Multiply (`ALU_SEQ_MUL_EN`): 7*6 -> 3 `ALU_ADD` cycles, `rsp_valid` cycle 5, data 42, cond 0; 0x12345678*0 -> `rsp_valid` cycle 2, data 0.
- Multiply overflow: 0xFFFFFFFF*0xFFFFFFFF, `MUL_STEPS`=32 -> `rsp_valid` cycle 34, data 0x00000001, cond 1.
- Macro undefined: `req_mul`=1, `req_op`=`ALU_ADD`, 2, 3 -> `rsp_valid` cycle 2, data 5.
